// File: rtl/sum_res_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub datapath between two requesters.
// Registers the operands and result, then holds the result DISP_HOLD cycles for the display.
module sum_res_arbiter #(
  parameter int WIDTH     = 4,
  parameter int DISP_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  input  logic [WIDTH:0]   alu_res,
  output logic [WIDTH:0]   res,
  output logic             res_owner,
  output logic             res_valid,
  output logic             busy
);

  localparam int CW = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last, owner, grant, xfer;

  // Only one requester valid wins outright; on contention the one not served last wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last;
  end

  // Gated by rst so neither port looks ready while reset is held.
  assign req0_ready = rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst && (state == IDLE) && req1_valid &&  grant;
  assign xfer       = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 1'b0;
      owner   <= 1'b0;
      last    <= 1'b1;
    end else if (xfer) begin
      alu_a   <= grant ? req1_a   : req0_a;
      alu_b   <= grant ? req1_b   : req0_b;
      alu_sel <= grant ? req1_sel : req0_sel;
      owner   <= grant;
      last    <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res       <= '0;
      res_owner <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      res_valid <= 1'b0;
      if (state == ISSUE) begin
        res       <= alu_res;
        res_owner <= owner;
        res_valid <= 1'b1;
        cnt       <= CW'(DISP_HOLD - 1);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_res_arbiter.sv
// Bench for sum_res_arbiter: cycle-timeline model checked every cycle plus directed literal checks.
module tb_sum_res_arbiter;
  localparam int W  = 4;
  localparam int DH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_sel, req0_ready;
  logic         req1_valid, req1_sel, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic         alu_sel, res_owner, res_valid, busy;
  logic [W:0]   alu_res, res;

  sum_res_arbiter #(.WIDTH(W), .DISP_HOLD(DH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .res(res), .res_owner(res_owner), .res_valid(res_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] addsub(input logic [W-1:0] a, b, input logic s);
    return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction

  assign alu_res = addsub(alu_a, alu_b, alu_sel);

  int errors = 0;
  int checks = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: acc_cyc is the cycle right after the last accept edge.
  // Busy for DH+1 cycles from there, result shows from the second of them.
  int           cyc = 0, acc_cyc = -100;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_sel = 1'b0, m_last = 1'b1, m_g = 1'b0, m_owner = 1'b0;
  logic [W:0]   m_res = '0;

  function automatic bit m_idle();
    return (cyc - acc_cyc) > DH;
  endfunction

  function automatic logic m_pick();
    if (req0_valid && req1_valid) return ~m_last;
    return req1_valid;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; acc_cyc = -100;
      m_a = '0; m_b = '0; m_sel = 1'b0; m_last = 1'b1; m_g = 1'b0;
      m_res = '0; m_owner = 1'b0;
    end else begin
      if (m_idle() && (req0_valid || req1_valid)) begin
        m_g   = m_pick();
        m_a   = m_g ? req1_a   : req0_a;
        m_b   = m_g ? req1_b   : req0_b;
        m_sel = m_g ? req1_sel : req0_sel;
        m_last  = m_g;
        acc_cyc = cyc + 1;
      end
      cyc++;
      if (cyc - acc_cyc == 1) begin
        m_res   = addsub(m_a, m_b, m_sel);
        m_owner = m_g;
      end
    end
  end

  int acc_cyc_log[$];
  int acc_own_log[$];
  int tb_cyc = 0;

  always @(negedge clk) begin
    logic idle_now, g_now;
    tb_cyc++;
    if (started) begin
      idle_now = rst && m_idle();
      g_now    = m_pick();
      chk("ready0",    req0_ready, idle_now && req0_valid && !g_now);
      chk("ready1",    req1_ready, idle_now && req1_valid &&  g_now);
      chk("busy",      busy,      rst && (cyc - acc_cyc) >= 0 && (cyc - acc_cyc) <= DH);
      chk("res_valid", res_valid, rst && (cyc - acc_cyc) == 1);
      chk("res",       res,       m_res);
      chk("res_owner", res_owner, m_owner);
      chk("alu_a",     alu_a,     m_a);
      chk("alu_b",     alu_b,     m_b);
      chk("alu_sel",   alu_sel,   m_sel);
      if (req0_valid && req0_ready) begin acc_cyc_log.push_back(tb_cyc); acc_own_log.push_back(0); end
      if (req1_valid && req1_ready) begin acc_cyc_log.push_back(tb_cyc); acc_own_log.push_back(1); end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    chk("idle_timeout", busy, 1'b0);
    step();
  endtask

  task automatic wait_ready(input int n);
    int t = 0;
    logic r;
    do begin
      @(negedge clk);
      r = n ? req1_ready : req0_ready;
      t++;
    end while (!r && t < 50);
    chk("ready_timeout", r, 1'b1);
  endtask

  task automatic run_op(input int n, input logic [W-1:0] a, b, input logic s, input logic [W:0] exp);
    int nb;
    if (n == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_sel = s; end
    else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_sel = s; end
    wait_ready(n);
    step();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("lit_alu_a", alu_a, a);
    chk("lit_alu_b", alu_b, b);
    @(negedge clk);
    chk("lit_res",       res,       exp);
    chk("lit_res_owner", res_owner, n[0]);
    chk("lit_res_valid", res_valid, 1'b1);
    nb = 2;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    chk("lit_busy_cycles", nb, DH + 1);
    step();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1; req0_a = 4'hF; req0_b = 4'h1; req0_sel = 0;
    req1_valid = 1; req1_a = 4'h7; req1_b = 4'h2; req1_sel = 1;
    #2 rst = 1'b0;
    started = 1;
    // 1: reset with both valids high
    repeat (3) @(negedge clk);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_res",    res,        '0);
    chk("rst_busy",   busy,       1'b0);
    chk("rst_alu_a",  alu_a,      '0);
    step();
    req0_valid = 0; req1_valid = 0;
    rst = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);

    // 2, 4, 3 (this order leaves last=1 so the contention run starts with req0)
    run_op(0, 4'd3, 4'd2, 1'b0, 5'h05);
    run_op(0, 4'd8, 4'd8, 1'b0, 5'h10);
    run_op(1, 4'd2, 4'd3, 1'b1, 5'h1F);

    // 5: both held valid for four grants
    acc_cyc_log.delete(); acc_own_log.delete();
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 0;
    req1_valid = 1; req1_a = 4'd5; req1_b = 4'd1; req1_sel = 1;
    for (int t = 0; t < 200 && acc_cyc_log.size() < 4; t++) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    chk("rr_count", acc_cyc_log.size(), 4);
    if (acc_cyc_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_owner", acc_own_log[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", acc_cyc_log[i] - acc_cyc_log[i-1], 2 + DH);
    end
    wait_idle();

    // 6: reset during HOLD, pending request served after release
    req0_valid = 1; req0_a = 4'd7; req0_b = 4'd1; req0_sel = 0;
    wait_ready(0);
    step();
    req0_valid = 0;
    step();
    step();
    chk("pre_rst_res", res, 5'h08);
    rst = 1'b0;
    req1_valid = 1; req1_a = 4'd9; req1_b = 4'd4; req1_sel = 1;
    #1;
    chk("abort_res",       res,       '0);
    chk("abort_busy",      busy,      1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    chk("abort_alu_a",     alu_a,     '0);
    step();
    rst = 1'b1;
    wait_ready(1);
    step();
    req1_valid = 0;
    @(negedge clk);
    chk("post_alu_a", alu_a, 4'd9);
    @(negedge clk);
    chk("post_res",   res,       5'h05);
    chk("post_owner", res_owner, 1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
